p09_block_state_memory: RTL and testbench

//  Storage for the breakout brick field: one BLOCKS_PER_ROW-bit presence word per block row.

---
 rtl/p09_block_state_memory_pkg.sv | 23 ++
 rtl/p09_popcount13.sv | 22 ++
 rtl/p09_block_state_memory.sv | 114 +++++++++++
 tb/tb_p09_block_state_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/p09_block_state_memory_pkg.sv
// rtl/p09_block_state_memory_pkg.sv - shared brick-field geometry, widths and state encoding
package p09_block_state_memory_pkg;

    localparam int BLOCKS_PER_ROW = 13;
    localparam int NUM_ROWS       = 15;
    localparam int ROW_W          = 4;
    localparam int CNT_W          = 8;
    localparam int POP_W          = 4;

    // Screen geometry shared with the painter and the ball/collision logic.
    localparam int BLOCK_WIDTH    = 48;
    localparam int BLOCK_HEIGHT   = 16;
    localparam int BORDER_WIDTH   = 8;

    localparam logic [BLOCKS_PER_ROW-1:0] INIT_PATTERN = 13'h1FFF;
    localparam logic [ROW_W-1:0]          LAST_ROW     = ROW_W'(NUM_ROWS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } bsm_state_t;

endpackage

// File: rtl/p09_popcount13.sv
// rtl/p09_popcount13.sv - combinational 13-bit population count as a balanced adder tree
module p09_popcount13 (
    input  logic [12:0] bits,
    output logic [3:0]  count
);

    logic [1:0] pair_sum [6];
    logic [2:0] quad_sum [3];
    logic [3:0] oct_sum;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            pair_sum[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
        end
        for (int j = 0; j < 3; j++) begin
            quad_sum[j] = {1'b0, pair_sum[2*j]} + {1'b0, pair_sum[2*j+1]};
        end
        oct_sum = {1'b0, quad_sum[0]} + {1'b0, quad_sum[1]};
        count   = oct_sum + {1'b0, quad_sum[2]} + {3'b000, bits[12]};
    end

endmodule

// File: rtl/p09_block_state_memory.sv
// rtl/p09_block_state_memory.sv - brick presence store with painter read/write-back, live count and level refill
import p09_block_state_memory_pkg::*;

module p09_block_state_memory (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      new_frame,
    input  logic                      go_next_line,
    input  logic                      write_block_line_state,
    input  logic [BLOCKS_PER_ROW-1:0] new_block_line_state,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    input  logic                      init_level,
    output logic                      init_busy,
    output logic [CNT_W-1:0]          blocks_remaining,
    output logic                      level_cleared
);

    logic [BLOCKS_PER_ROW-1:0] mem [NUM_ROWS];

    bsm_state_t                state_q, state_d;
    logic [ROW_W-1:0]          init_row_q, init_row_d;
    logic [ROW_W-1:0]          row_ptr_q, row_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      cleared_q;

    logic [BLOCKS_PER_ROW-1:0] cur_row;
    logic [BLOCKS_PER_ROW-1:0] removed_mask;
    logic [POP_W-1:0]          init_pop;
    logic [POP_W-1:0]          removed_pop;
    logic [CNT_W-1:0]          init_pop_ext;
    logic [CNT_W-1:0]          removed_ext;

    assign cur_row      = mem[row_ptr_q];
    assign removed_mask = cur_row & ~new_block_line_state;
    assign init_pop_ext = {{(CNT_W-POP_W){1'b0}}, init_pop};
    assign removed_ext  = {{(CNT_W-POP_W){1'b0}}, removed_pop};

    p09_popcount13 u_pop_init (
        .bits  (INIT_PATTERN),
        .count (init_pop)
    );

    p09_popcount13 u_pop_removed (
        .bits  (removed_mask),
        .count (removed_pop)
    );

    always_comb begin
        state_d    = state_q;
        init_row_d = init_row_q;
        count_d    = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init_level) begin
                    state_d    = ST_INIT;
                    init_row_d = '0;
                    count_d    = '0;
                end else if (write_block_line_state) begin
                    // Saturate so a stale count can never wrap to a huge value.
                    count_d = (count_q > removed_ext) ? (count_q - removed_ext) : '0;
                end
            end
            ST_INIT: begin
                count_d    = count_q + init_pop_ext;
                init_row_d = init_row_q + 1'b1;
                if (init_row_q == LAST_ROW) begin
                    state_d    = ST_IDLE;
                    init_row_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_ptr_d = row_ptr_q;
        if (new_frame) begin
            row_ptr_d = '0;
        end else if (go_next_line) begin
            row_ptr_d = (row_ptr_q == LAST_ROW) ? '0 : row_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                mem[i] <= '0;
            end
            state_q    <= ST_INIT;
            init_row_q <= '0;
            row_ptr_q  <= '0;
            count_q    <= '0;
            cleared_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_row_q <= init_row_d;
            row_ptr_q  <= row_ptr_d;
            count_q    <= count_d;
            cleared_q  <= (state_q == ST_IDLE) && (count_q == '0);
            if (state_q == ST_INIT) begin
                mem[init_row_q] <= INIT_PATTERN;
            end else if (write_block_line_state) begin
                // AND-only write-back: a block can vanish but never reappear.
                mem[row_ptr_q] <= cur_row & new_block_line_state;
            end
        end
    end

    assign init_busy        = (state_q == ST_INIT);
    assign block_line_state = init_busy ? '0 : cur_row;
    assign blocks_remaining = count_q;
    assign level_cleared    = cleared_q;

endmodule

// File: tb/tb_p09_block_state_memory.sv
// tb/tb_p09_block_state_memory.sv - randomized and directed self-checking bench against a behavioural field model
module tb_p09_block_state_memory;

    logic        clk = 1'b0;
    logic        nRst;
    logic        new_frame;
    logic        go_next_line;
    logic        write_block_line_state;
    logic [12:0] new_block_line_state;
    logic [12:0] block_line_state;
    logic        init_level;
    logic        init_busy;
    logic [7:0]  blocks_remaining;
    logic        level_cleared;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_mem [15];
    int          m_ptr;
    int          m_cnt;
    int          m_init_left;
    logic        m_clr;

    always #5 clk = ~clk;

    p09_block_state_memory dut (
        .clk                    (clk),
        .nRst                   (nRst),
        .new_frame              (new_frame),
        .go_next_line           (go_next_line),
        .write_block_line_state (write_block_line_state),
        .new_block_line_state   (new_block_line_state),
        .block_line_state       (block_line_state),
        .init_level             (init_level),
        .init_busy              (init_busy),
        .blocks_remaining       (blocks_remaining),
        .level_cleared          (level_cleared)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit   idle;
        int   removed;
        if (!nRst) begin
            for (int i = 0; i < 15; i++) m_mem[i] = '0;
            m_ptr = 0; m_cnt = 0; m_clr = 1'b0; m_init_left = 15;
            return;
        end
        idle = (m_init_left == 0);
        m_clr = idle && (m_cnt == 0);
        if (!idle) begin
            m_mem[15 - m_init_left] = 13'h1FFF;
            m_cnt += 13;
            m_init_left--;
        end else begin
            if (write_block_line_state) begin
                removed = $countones(m_mem[m_ptr] & ~new_block_line_state);
                m_mem[m_ptr] &= new_block_line_state;
                m_cnt = (m_cnt >= removed) ? m_cnt - removed : 0;
            end
            if (init_level) begin
                m_init_left = 15;
                m_cnt = 0;
            end
        end
        if (new_frame) m_ptr = 0;
        else if (go_next_line) m_ptr = (m_ptr + 1) % 15;
    endtask

    task automatic compare_all();
        check("read", 32'(block_line_state), 32'((m_init_left > 0) ? 13'h0 : m_mem[m_ptr]));
        check("busy", 32'(init_busy), 32'(m_init_left > 0));
        check("count", 32'(blocks_remaining), 32'(m_cnt));
        check("cleared", 32'(level_cleared), 32'(m_clr));
    endtask

    // One clock: DUT and model see the same inputs, then outputs are compared and pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        new_frame = 0; go_next_line = 0; write_block_line_state = 0; init_level = 0;
        new_block_line_state = '0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            go_next_line = 1;
            tick();
        end
    endtask

    task automatic wr(input logic [12:0] d);
        write_block_line_state = 1;
        new_block_line_state = d;
        tick();
    endtask

    logic [12:0] row0_word;
    int          bit_idx;

    initial begin
        nRst = 0; new_frame = 0; go_next_line = 0; write_block_line_state = 0;
        new_block_line_state = '0; init_level = 0;

        // 1: reset, automatic sweep, all rows full
        tick();
        check("rst_count", 32'(blocks_remaining), 32'd0);
        check("rst_cleared", 32'(level_cleared), 32'd0);
        nRst = 1;
        for (int i = 0; i < 15; i++) begin
            check("sweep_busy", 32'(init_busy), 32'd1);
            tick();
        end
        check("sweep_done", 32'(init_busy), 32'd0);
        check("full_count", 32'(blocks_remaining), 32'd195);
        check("full_cleared", 32'(level_cleared), 32'd0);
        for (int r = 0; r < 15; r++) begin
            check("full_row", 32'(block_line_state), 32'h1FFF);
            advance(1);
        end

        // 2: clear bits 0 and 3 of row 3, then rewrite identically
        advance(3);
        wr(13'h1FF6);
        check("row3_word", 32'(block_line_state), 32'h1FF6);
        check("row3_count", 32'(blocks_remaining), 32'd193);
        wr(13'h1FF6);
        check("rewrite_count", 32'(blocks_remaining), 32'd193);

        // 3: no resurrection
        wr(13'h1FFF);
        check("no_resurrect", 32'(block_line_state), 32'h1FF6);
        check("no_resurrect_cnt", 32'(blocks_remaining), 32'd193);

        // random painter traffic
        for (int i = 0; i < 300; i++) begin
            go_next_line = ($urandom_range(0, 2) != 0);
            new_frame = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) begin
                bit_idx = $urandom_range(0, 12);
                write_block_line_state = 1;
                new_block_line_state = ~(13'h1 << bit_idx) | 13'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) new_block_line_state = 13'($urandom);
            end
            tick();
        end

        // 4: pointer wrap and new_frame priority
        new_frame = 1;
        tick();
        row0_word = m_mem[0];
        advance(15);
        check("wrap_row0", 32'(block_line_state), 32'(row0_word));
        advance(7);
        new_frame = 1;
        go_next_line = 1;
        tick();
        check("nf_priority", 32'(block_line_state), 32'(row0_word));

        // 5: clear every row (write and advance together), then reload
        for (int r = 0; r < 15; r++) begin
            go_next_line = 1;
            wr(13'h0);
        end
        check("empty_count", 32'(blocks_remaining), 32'd0);
        tick();
        check("cleared_high", 32'(level_cleared), 32'd1);
        init_level = 1;
        tick();
        check("reload_busy", 32'(init_busy), 32'd1);
        for (int i = 0; i < 14; i++) tick();
        check("cleared_low", 32'(level_cleared), 32'd0);
        check("reload_busy_end", 32'(init_busy), 32'd1);
        tick();
        check("reload_done", 32'(init_busy), 32'd0);
        check("reload_count", 32'(blocks_remaining), 32'd195);

        // 6: write during INIT is ignored; reset mid-sweep restarts
        init_level = 1;
        tick();
        wr(13'h0);
        check("init_read_zero", 32'(block_line_state), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        nRst = 0;
        tick();
        check("midrst_count", 32'(blocks_remaining), 32'd0);
        nRst = 1;
        for (int i = 0; i < 15; i++) begin
            check("resweep_busy", 32'(init_busy), 32'd1);
            tick();
        end
        check("resweep_done", 32'(init_busy), 32'd0);
        check("resweep_count", 32'(blocks_remaining), 32'd195);
        for (int r = 0; r < 15; r++) begin
            check("resweep_row", 32'(block_line_state), 32'h1FFF);
            advance(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
